// File: rtl/output_drain_ctrl_if.sv
// Handshake and BRAM-side signals between the output drain controller and its
// driver: job control, array result handshake, output-block mux control, BRAM port A.
interface output_drain_ctrl_if #(
   parameter int SEL_WIDTH_MUX_OUT_1 = 2,
   parameter int SEL_WIDTH_MUX_OUT_2 = 2,
   parameter int BRAM_ADDR_WIDTH     = 11,
   parameter int COUNTER_ROUND_WIDTH = 3
);
   logic                           start_i;
   logic [BRAM_ADDR_WIDTH-1:0]     n_pixels_i;
   logic [COUNTER_ROUND_WIDTH-1:0] n_rounds_i;
   logic                           result_valid_i;
   logic                           ready_o;
   logic                           mux_out_reg_wr_en_o;
   logic                           sel_mux_out_ld_o;
   logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o;
   logic                           bram_wr_en_a_o;
   logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_write_read_o;
   logic                           busy_o;
   logic                           done_o;
   logic                           overrun_o;
   logic                           addr_wrap_o;

   modport master (
      output start_i, n_pixels_i, n_rounds_i, result_valid_i,
      input  ready_o, mux_out_reg_wr_en_o, sel_mux_out_ld_o, sel_mux_out_1_o,
             sel_mux_out_2_o, bram_wr_en_a_o, bram_addr_write_read_o, busy_o,
             done_o, overrun_o, addr_wrap_o
   );

   modport slave (
      input  start_i, n_pixels_i, n_rounds_i, result_valid_i,
      output ready_o, mux_out_reg_wr_en_o, sel_mux_out_ld_o, sel_mux_out_1_o,
             sel_mux_out_2_o, bram_wr_en_a_o, bram_addr_write_read_o, busy_o,
             done_o, overrun_o, addr_wrap_o
   );
endinterface

// File: rtl/output_drain_ctrl.sv
// Sequences one systolic-array result vector per pixel: capture, drain column by
// column through the two-level output mux, then write one BRAM word.
module output_drain_ctrl #(
   parameter int N_COLS_ARRAY        = 16,
   parameter int NUMBER_MUX_OUT_1    = 4,
   parameter int SEL_WIDTH_MUX_OUT_1 = 2,
   parameter int SEL_WIDTH_MUX_OUT_2 = 2,
   parameter int BRAM_ADDR_WIDTH     = 11,
   parameter int COUNTER_ROUND_WIDTH = 3
) (
   input logic                clk_i,
   input logic                general_rst_i,
   output_drain_ctrl_if.slave bus
);
   localparam int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1;
   localparam int COL_W = (N_COLS_ARRAY > 1) ? $clog2(N_COLS_ARRAY) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS_ARRAY - 1);

   typedef enum logic [2:0] {IDLE, WAIT_RES, CAPTURE, DRAIN, WRITE, DONE} state_t;

   state_t                         state_reg, state_next;
   logic [BRAM_ADDR_WIDTH-1:0]     n_pixels_reg, n_pixels_next;
   logic [BRAM_ADDR_WIDTH-1:0]     pixel_cnt_reg, pixel_cnt_next;
   logic [BRAM_ADDR_WIDTH-1:0]     addr_ptr_reg, addr_ptr_next;
   logic [COUNTER_ROUND_WIDTH-1:0] n_rounds_reg, n_rounds_next;
   logic [COUNTER_ROUND_WIDTH-1:0] round_cnt_reg, round_cnt_next;
   logic [COL_W-1:0]               col_cnt_reg, col_cnt_next;
   logic                           overrun_reg, overrun_next;
   logic                           addr_wrap_reg, addr_wrap_next;

   logic                           ready_reg, ready_next;
   logic                           wr_en_reg, wr_en_next;
   logic                           ld_reg, ld_next;
   logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_1_reg, sel_1_next;
   logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_2_reg, sel_2_next;
   logic                           bram_we_reg, bram_we_next;
   logic [BRAM_ADDR_WIDTH-1:0]     addr_out_reg, addr_out_next;
   logic                           busy_reg, busy_next;
   logic                           done_reg, done_next;

   always_ff @(posedge clk_i) begin
      if (general_rst_i) begin
         state_reg     <= IDLE;
         n_pixels_reg  <= '0;
         pixel_cnt_reg <= '0;
         addr_ptr_reg  <= '0;
         n_rounds_reg  <= '0;
         round_cnt_reg <= '0;
         col_cnt_reg   <= '0;
         overrun_reg   <= 1'b0;
         addr_wrap_reg <= 1'b0;
         ready_reg     <= 1'b0;
         wr_en_reg     <= 1'b0;
         ld_reg        <= 1'b0;
         sel_1_reg     <= '0;
         sel_2_reg     <= '0;
         bram_we_reg   <= 1'b0;
         addr_out_reg  <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         n_pixels_reg  <= n_pixels_next;
         pixel_cnt_reg <= pixel_cnt_next;
         addr_ptr_reg  <= addr_ptr_next;
         n_rounds_reg  <= n_rounds_next;
         round_cnt_reg <= round_cnt_next;
         col_cnt_reg   <= col_cnt_next;
         overrun_reg   <= overrun_next;
         addr_wrap_reg <= addr_wrap_next;
         ready_reg     <= ready_next;
         wr_en_reg     <= wr_en_next;
         ld_reg        <= ld_next;
         sel_1_reg     <= sel_1_next;
         sel_2_reg     <= sel_2_next;
         bram_we_reg   <= bram_we_next;
         addr_out_reg  <= addr_out_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      n_pixels_next  = n_pixels_reg;
      pixel_cnt_next = pixel_cnt_reg;
      addr_ptr_next  = addr_ptr_reg;
      n_rounds_next  = n_rounds_reg;
      round_cnt_next = round_cnt_reg;
      col_cnt_next   = col_cnt_reg;
      overrun_next   = overrun_reg;
      addr_wrap_next = addr_wrap_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start_i) begin
               n_pixels_next  = bus.n_pixels_i;
               n_rounds_next  = bus.n_rounds_i;
               pixel_cnt_next = '0;
               round_cnt_next = '0;
               col_cnt_next   = '0;
               addr_ptr_next  = '0;
               overrun_next   = 1'b0;
               addr_wrap_next = 1'b0;
               state_next = (bus.n_pixels_i == '0 || bus.n_rounds_i == '0) ? DONE : WAIT_RES;
            end
         end
         WAIT_RES: if (bus.result_valid_i) state_next = CAPTURE;
         CAPTURE: begin
            col_cnt_next = '0;
            state_next   = DRAIN;
         end
         DRAIN: begin
            if (col_cnt_reg == COL_LAST) begin
               col_cnt_next = '0;
               state_next   = WRITE;
            end else begin
               col_cnt_next = col_cnt_reg + COL_W'(1);
            end
         end
         WRITE: begin
            addr_ptr_next = addr_ptr_reg + BRAM_ADDR_WIDTH'(1);
            if (&addr_ptr_reg) addr_wrap_next = 1'b1;
            if (pixel_cnt_reg != n_pixels_reg - BRAM_ADDR_WIDTH'(1)) begin
               pixel_cnt_next = pixel_cnt_reg + BRAM_ADDR_WIDTH'(1);
               state_next     = WAIT_RES;
            end else if (round_cnt_reg != n_rounds_reg - COUNTER_ROUND_WIDTH'(1)) begin
               round_cnt_next = round_cnt_reg + COUNTER_ROUND_WIDTH'(1);
               pixel_cnt_next = '0;
               state_next     = WAIT_RES;
            end else begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // A result arriving while the previous vector is still being drained is lost.
      if (bus.result_valid_i && (state_reg inside {CAPTURE, DRAIN, WRITE}))
         overrun_next = 1'b1;

      // Outputs are decoded from the next state so the registered copies line up with the state.
      ready_next    = (state_next == WAIT_RES);
      wr_en_next    = (state_next == CAPTURE);
      ld_next       = (state_next == DRAIN);
      bram_we_next  = (state_next == WRITE);
      busy_next     = (state_next != IDLE);
      done_next     = (state_next == DONE);
      addr_out_next = addr_ptr_next;
      sel_1_next    = '0;
      sel_2_next    = '0;
      if (state_next == DRAIN) begin
         sel_1_next = SEL_WIDTH_MUX_OUT_1'(int'(col_cnt_next) % NUMBER_INPUT_MUX_OUT_1);
         sel_2_next = SEL_WIDTH_MUX_OUT_2'(int'(col_cnt_next) / NUMBER_INPUT_MUX_OUT_1);
      end
   end

   assign bus.ready_o                = ready_reg;
   assign bus.mux_out_reg_wr_en_o    = wr_en_reg;
   assign bus.sel_mux_out_ld_o       = ld_reg;
   assign bus.sel_mux_out_1_o        = sel_1_reg;
   assign bus.sel_mux_out_2_o        = sel_2_reg;
   assign bus.bram_wr_en_a_o         = bram_we_reg;
   assign bus.bram_addr_write_read_o = addr_out_reg;
   assign bus.busy_o                 = busy_reg;
   assign bus.done_o                 = done_reg;
   assign bus.overrun_o              = overrun_reg;
   assign bus.addr_wrap_o            = addr_wrap_reg;
endmodule
